// File: rtl/mem34_reader.sv
// Read side of the mem34 parameter memory: walks an address window and sends it to the
// serial transmitter as a framed stream (header, address, count, data, checksum).
module mem34_reader #(
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned READ_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] start_addr,
  input  logic [5:0] count,
  output logic [5:0] mem34_addr_r,
  input  logic [7:0] mem34_xout,
  output logic [7:0] t_byte,
  output logic       t_valid,
  input  logic       t_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ADR  = 3'd2,
    CNT  = 3'd3,
    RD   = 3'd4,
    WAIT = 3'd5,
    DATA = 3'd6,
    CSUM = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_d;
  logic       valid_d;
  logic [5:0] addr_d;
  logic       busy_d;
  logic       done_d;
  logic [5:0] saddr_q, saddr_d;
  logic [5:0] cnt_q, cnt_d;
  logic [6:0] rem_q, rem_d;
  logic [2:0] lat_q, lat_d;
  logic [7:0] sum_q, sum_d;

  logic       xfer;
  logic [7:0] sum_add;

  assign xfer    = t_valid & t_ready;
  assign sum_add = sum_q + t_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      t_byte       <= 8'd0;
      t_valid      <= 1'b0;
      mem34_addr_r <= 6'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      saddr_q      <= 6'd0;
      cnt_q        <= 6'd0;
      rem_q        <= 7'd0;
      lat_q        <= 3'd0;
      sum_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      t_byte       <= byte_d;
      t_valid      <= valid_d;
      mem34_addr_r <= addr_d;
      busy         <= busy_d;
      done         <= done_d;
      saddr_q      <= saddr_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      lat_q        <= lat_d;
      sum_q        <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    byte_d  = t_byte;
    valid_d = t_valid;
    addr_d  = mem34_addr_r;
    busy_d  = busy;
    done_d  = 1'b0;
    saddr_d = saddr_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    sum_d   = xfer ? sum_add : sum_q;

    case (state_q)
      IDLE: begin
        // done high means CSUM was only just accepted; a start in that cycle is dropped
        if (start && !done) begin
          state_d = HDR;
          busy_d  = 1'b1;
          addr_d  = start_addr;
          saddr_d = start_addr;
          cnt_d   = count;
          rem_d   = (count == 6'd0) ? 7'd64 : {1'b0, count};
          byte_d  = HEADER;
          valid_d = 1'b1;
          sum_d   = 8'd0;
        end
      end
      HDR: begin
        if (xfer) begin
          byte_d  = {2'b00, saddr_q};
          state_d = ADR;
        end
      end
      ADR: begin
        if (xfer) begin
          byte_d  = {2'b00, cnt_q};
          state_d = CNT;
        end
      end
      CNT: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = RD;
        end
      end
      RD: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          byte_d  = mem34_xout;
          valid_d = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          rem_d = rem_q - 7'd1;
          if (rem_q != 7'd1) begin
            addr_d  = mem34_addr_r + 6'd1;
            valid_d = 1'b0;
            state_d = RD;
          end else begin
            // trailer makes the whole frame sum to zero mod 256
            byte_d  = 8'd0 - sum_add;
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem34_reader.sv
// Scoreboard bench for mem34_reader: expected frame bytes are queued by the stimulus,
// a monitor pops and compares them on every transfer.
module tb_mem34_reader;

  localparam int READ_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] start_addr;
  logic [5:0] count;
  logic [5:0] mem34_addr_r;
  logic [7:0] mem34_xout;
  logic [7:0] t_byte;
  logic       t_valid;
  logic       t_ready;
  logic       busy;
  logic       done;

  mem34_reader #(.HEADER(8'hA5), .READ_LAT(READ_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .count        (count),
    .mem34_addr_r (mem34_addr_r),
    .mem34_xout   (mem34_xout),
    .t_byte       (t_byte),
    .t_valid      (t_valid),
    .t_ready      (t_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // memory with READ_LAT cycles from address to data
  logic [7:0] mem [64];
  logic [7:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem34_addr_r];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem34_xout = rd_pipe[READ_LAT-1];

  logic [7:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int dones  = 0;
  bit stall_mode = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic send_start(input logic [5:0] a, input logic [5:0] c);
    start_addr = a;
    count      = c;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      cyc();
      n++;
    end
    chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (xfers < target && n < budget) begin
      cyc();
      n++;
    end
    chk({name, "_xfer_reach"}, (xfers >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // transmitter: always ready, or ready only after 10 low cycles per byte
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    t_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        t_ready   = 1'b1;
        stall_cnt = 0;
      end else if (t_valid && stall_cnt < 10) begin
        t_ready = 1'b0;
        stall_cnt++;
      end else begin
        t_ready   = t_valid;
        stall_cnt = 0;
      end
    end
  end

  // monitor
  initial begin
    bit         pend;
    logic [7:0] pend_byte;
    logic [7:0] fsum;
    logic [7:0] e;
    bit         prev_done;
    pend = 0; pend_byte = 8'd0; fsum = 8'd0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
        fsum = 8'd0;
        prev_done = 0;
      end else begin
        if (pend) begin
          checks++;
          if (!(t_valid === 1'b1 && t_byte === pend_byte)) begin
            errors++;
            $display("FAIL hold: valid=%0b byte=%02h, expected valid=1 byte=%02h",
                     t_valid, t_byte, pend_byte);
          end
        end
        pend      = t_valid && !t_ready;
        pend_byte = t_byte;
        if (t_valid && t_ready) begin
          checks++;
          xfers++;
          fsum = fsum + t_byte;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_byte: got %02h, expected no transfer", t_byte);
          end else begin
            e = exp_q.pop_front();
            if (t_byte !== e) begin
              errors++;
              $display("FAIL byte%0d: got %02h, expected %02h", xfers, t_byte, e);
            end
          end
        end
        if (done) begin
          dones++;
          checks++;
          if (fsum !== 8'd0 || busy !== 1'b0 || prev_done) begin
            errors++;
            $display("FAIL frame_end: sum=%02h busy=%0b prev_done=%0b, expected 00 0 0",
                     fsum, busy, prev_done);
          end
          fsum = 8'd0;
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int d0, x0;
    logic [7:0] s, b;
    rst = 1'b1; start = 1'b0; start_addr = 6'd0; count = 6'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h81; mem[1] = 8'h40; mem[62] = 8'h11; mem[63] = 8'h22;
    repeat (3) cyc();
    chk("rst_valid", {31'd0, t_valid}, 32'd0);
    chk("rst_byte", {24'd0, t_byte}, 32'd0);
    chk("rst_addr", {26'd0, mem34_addr_r}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    cyc();

    // 1: two bytes from address 0; A5+00+02+81+40 = 68 -> trailer 98
    d0 = dones;
    push(8'hA5); push(8'h00); push(8'h02); push(8'h81); push(8'h40); push(8'h98);
    send_start(6'd0, 6'd2);
    chk("c1_busy", {31'd0, busy}, 32'd1);
    wait_done(100, "c1");
    cyc();
    chk("c1_dones", 32'(dones - d0), 32'd1);
    chk("c1_queue", 32'(exp_q.size()), 32'd0);

    // 2: wrap 62,63,0,1; sum DB -> trailer 25
    x0 = xfers;
    push(8'hA5); push(8'h3E); push(8'h04); push(8'h11); push(8'h22); push(8'h81); push(8'h40);
    push(8'h25);
    send_start(6'd62, 6'd4);
    wait_done(100, "c2");
    chk("c2_busy_at_done", {31'd0, busy}, 32'd0);
    cyc();
    chk("c2_xfers", 32'(xfers - x0), 32'd8);
    chk("c2_busy_after", {31'd0, busy}, 32'd0);

    // 3: count 0 means 64 bytes from 5 around to 4
    x0 = xfers;
    push(8'hA5); push(8'h05); push(8'h00);
    s = 8'hA5 + 8'h05;
    for (int i = 0; i < 64; i++) begin
      b = mem[(5 + i) % 64];
      push(b);
      s = s + b;
    end
    push(8'd0 - s);
    send_start(6'd5, 6'd0);
    wait_done(600, "c3");
    cyc();
    chk("c3_xfers", 32'(xfers - x0), 32'd68);
    chk("c3_queue", 32'(exp_q.size()), 32'd0);

    // 4: ten stall cycles on every byte, same frame as 1
    stall_mode = 1'b1;
    push(8'hA5); push(8'h00); push(8'h02); push(8'h81); push(8'h40); push(8'h98);
    send_start(6'd0, 6'd2);
    wait_done(300, "c4");
    stall_mode = 1'b0;
    cyc();
    chk("c4_queue", 32'(exp_q.size()), 32'd0);

    // 5: start during data and in the done cycle ignored; held one more cycle it is taken
    // second frame from addr 0 count 1: A5+01+81 = 27 -> trailer D9
    d0 = dones;
    x0 = xfers;
    push(8'hA5); push(8'h00); push(8'h02); push(8'h81); push(8'h40); push(8'h98);
    push(8'hA5); push(8'h00); push(8'h01); push(8'h81); push(8'hD9);
    send_start(6'd0, 6'd2);
    wait_xfers(x0 + 4, 100, "c5");
    send_start(6'd10, 6'd3);
    wait_done(100, "c5a");
    start_addr = 6'd10; count = 6'd3; start = 1'b1;
    cyc();
    start_addr = 6'd0; count = 6'd1;
    cyc();
    start = 1'b0;
    chk("c5_busy_restart", {31'd0, busy}, 32'd1);
    wait_done(100, "c5b");
    repeat (20) cyc();
    chk("c5_dones", 32'(dones - d0), 32'd2);
    chk("c5_xfers", 32'(xfers - x0), 32'd11);
    chk("c5_idle_valid", {31'd0, t_valid}, 32'd0);

    // 6: reset after the third data byte, then a clean frame
    d0 = dones;
    x0 = xfers;
    push(8'hA5); push(8'h3E); push(8'h05); push(8'h11); push(8'h22); push(8'h81);
    send_start(6'd62, 6'd5);
    wait_xfers(x0 + 6, 100, "c6");
    rst = 1'b1;
    cyc();
    chk("c6_valid", {31'd0, t_valid}, 32'd0);
    chk("c6_busy", {31'd0, busy}, 32'd0);
    chk("c6_addr", {26'd0, mem34_addr_r}, 32'd0);
    chk("c6_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("c6_queue_mid", 32'(exp_q.size()), 32'd0);
    push(8'hA5); push(8'h00); push(8'h02); push(8'h81); push(8'h40); push(8'h98);
    send_start(6'd0, 6'd2);
    wait_done(100, "c6");
    cyc();
    chk("c6_dones", 32'(dones - d0), 32'd1);

    repeat (5) cyc();
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
